// File: rtl/cisc_mem_arbiter_if.sv
// cisc_mem_arbiter_if: bundles the fetch port, datapath port and memory bus of
// the CISC memory arbiter. The 'slave' modport is the arbiter's view; the
// 'master' modport is the requesters' and memory's view.
// Latency: none (wires only). Backpressure: none (pure signal bundle).
interface cisc_mem_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  // instruction-fetch port (read-only)
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  // execute-datapath port (read/write)
  logic              dp_req;
  logic              dp_we;
  logic [ADDR_W-1:0] dp_addr;
  logic [DATA_W-1:0] dp_wdata;
  logic              dp_gnt;
  logic              dp_rvalid;
  logic [DATA_W-1:0] dp_rdata;
  // memory bus
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] mem_out;

  modport slave (
    input  if_req, if_addr, dp_req, dp_we, dp_addr, dp_wdata, mem_out,
    output if_gnt, if_rvalid, if_rdata, dp_gnt, dp_rvalid, dp_rdata,
           mem_addr, mem_din, read, write
  );

  modport master (
    output if_req, if_addr, dp_req, dp_we, dp_addr, dp_wdata, mem_out,
    input  if_gnt, if_rvalid, if_rdata, dp_gnt, dp_rvalid, dp_rdata,
           mem_addr, mem_din, read, write
  );
endinterface

// File: rtl/cisc_mem_arbiter.sv
// cisc_mem_arbiter: shares one memory between instruction fetch and the execute
//   datapath; round-robin arbitration, or fixed datapath priority when
//   ARB_FIXED_PRIO_EN is defined.
// Latency: grant + strobe one cycle after the request is sampled; write done in
//   2 cycles; read data valid pulse RD_LAT+2 cycles after the request.
// Backpressure: requesters hold req until their grant; requests are ignored
//   while an access is in flight.
// Ports: clk, reset (sync, active-high); bus (cisc_mem_arbiter_if.slave) carries
//   the if_* fetch port, dp_* datapath port and mem_addr/mem_din/read/write/mem_out.
module cisc_mem_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic               clk,
  input  logic               reset,
  cisc_mem_arbiter_if.slave  bus
);

  if (RD_LAT < 1 || RD_LAT > 7) begin : g_lat_chk
    $error("cisc_mem_arbiter: RD_LAT must be in 1..7");
  end

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT} state_t;

  state_t            state_q, state_d;
  logic              owner_dp_q, owner_dp_d;   // 1 = datapath owns the access
  logic              we_q, we_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_din_q, mem_din_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dp_rdata_q, dp_rdata_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              dp_rvalid_q, dp_rvalid_d;
  logic              pick_dp;
  logic              if_gnt_c, dp_gnt_c, read_c, write_c;

`ifdef ARB_FIXED_PRIO_EN
  assign pick_dp = bus.dp_req;
`else
  logic last_dp_q, last_dp_d;  // 1 = datapath was granted most recently
  // Datapath wins if alone, or on a tie when fetch was served last.
  assign pick_dp = bus.dp_req && (!bus.if_req || !last_dp_q);
`endif

  always_comb begin
    state_d     = state_q;
    owner_dp_d  = owner_dp_q;
    we_d        = we_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;
    if_rdata_d  = if_rdata_q;
    dp_rdata_d  = dp_rdata_q;
    if_rvalid_d = 1'b0;
    dp_rvalid_d = 1'b0;
    if_gnt_c    = 1'b0;
    dp_gnt_c    = 1'b0;
    read_c      = 1'b0;
    write_c     = 1'b0;
`ifndef ARB_FIXED_PRIO_EN
    last_dp_d   = last_dp_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.if_req || bus.dp_req) begin
          state_d    = ACCESS;
          owner_dp_d = pick_dp;
`ifndef ARB_FIXED_PRIO_EN
          last_dp_d  = pick_dp;
`endif
          if (pick_dp) begin
            mem_addr_d = bus.dp_addr;
            we_d       = bus.dp_we;
            if (bus.dp_we) mem_din_d = bus.dp_wdata;
          end else begin
            mem_addr_d = bus.if_addr;
            we_d       = 1'b0;
          end
        end
      end
      ACCESS: begin
        if_gnt_c = !owner_dp_q;
        dp_gnt_c = owner_dp_q;
        write_c  = we_q;
        read_c   = !we_q;
        if (we_q) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT;
          cnt_d   = 3'(RD_LAT);
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        // cnt_q == 1 is the cycle in which memory data is valid.
        if (cnt_q == 3'd1) begin
          state_d = IDLE;
          if (owner_dp_q) begin
            dp_rdata_d  = bus.mem_out;
            dp_rvalid_d = 1'b1;
          end else begin
            if_rdata_d  = bus.mem_out;
            if_rvalid_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_dp_q  <= 1'b0;
      we_q        <= 1'b0;
      cnt_q       <= 3'd0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      if_rdata_q  <= '0;
      dp_rdata_q  <= '0;
      if_rvalid_q <= 1'b0;
      dp_rvalid_q <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      last_dp_q   <= 1'b1;  // fetch wins the first tie after reset
`endif
    end else begin
      state_q     <= state_d;
      owner_dp_q  <= owner_dp_d;
      we_q        <= we_d;
      cnt_q       <= cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      if_rdata_q  <= if_rdata_d;
      dp_rdata_q  <= dp_rdata_d;
      if_rvalid_q <= if_rvalid_d;
      dp_rvalid_q <= dp_rvalid_d;
`ifndef ARB_FIXED_PRIO_EN
      last_dp_q   <= last_dp_d;
`endif
    end
  end

  assign bus.if_gnt    = if_gnt_c;
  assign bus.dp_gnt    = dp_gnt_c;
  assign bus.read      = read_c;
  assign bus.write     = write_c;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_din   = mem_din_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dp_rdata  = dp_rdata_q;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.dp_rvalid = dp_rvalid_q;

endmodule

// File: tb/tb_cisc_mem_arbiter.sv
// Testbench for cisc_mem_arbiter: one instance with RD_LAT=1 (b1) and one with
// RD_LAT=3 (b3), each with its own 32x8 memory model.
module tb_cisc_mem_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vec = 0;
  int   err = 0;

  always #5 clk = ~clk;

  cisc_mem_arbiter_if #(.ADDR_W(5), .DATA_W(8)) b1 ();
  cisc_mem_arbiter_if #(.ADDR_W(5), .DATA_W(8)) b3 ();

  cisc_mem_arbiter #(.ADDR_W(5), .DATA_W(8), .RD_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset), .bus(b1.slave));
  cisc_mem_arbiter #(.ADDR_W(5), .DATA_W(8), .RD_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset), .bus(b3.slave));

  // Memory models: data is valid only in the RD_LAT-th cycle after the read
  // strobe; any other cycle shows 8'hEE so mistimed capture is visible.
  logic [7:0] mem1 [32];
  logic [7:0] mem3 [32];
  logic       init_done = 1'b0;
  logic [4:0] ra1 = '0, ra3 = '0;
  logic [2:0] rc1 = '0, rc3 = '0;

  function automatic logic [7:0] preset(input int i);
    case (i)
      0: preset = 8'h5A;
      2: preset = 8'hC3;
      3: preset = 8'hA5;
      7: preset = 8'h77;
      default: preset = 8'(i) ^ 8'h80;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 32; i++) begin
        mem1[i] <= preset(i);
        mem3[i] <= preset(i);
      end
      init_done <= 1'b1;
    end else begin
      if (b1.write) mem1[b1.mem_addr] <= b1.mem_din;
      if (b3.write) mem3[b3.mem_addr] <= b3.mem_din;
    end
    if (b1.read) begin ra1 <= b1.mem_addr; rc1 <= 3'd1; end
    else if (rc1 != 3'd0) rc1 <= (rc1 == 3'd7) ? 3'd0 : rc1 + 3'd1;
    if (b3.read) begin ra3 <= b3.mem_addr; rc3 <= 3'd1; end
    else if (rc3 != 3'd0) rc3 <= (rc3 == 3'd7) ? 3'd0 : rc3 + 3'd1;
  end

  assign b1.mem_out = (rc1 == 3'd1) ? mem1[ra1] : 8'hEE;
  assign b3.mem_out = (rc3 == 3'd3) ? mem3[ra3] : 8'hEE;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    b1.if_req = 0; b1.if_addr = '0; b1.dp_req = 0; b1.dp_we = 0; b1.dp_addr = '0; b1.dp_wdata = '0;
    b3.if_req = 0; b3.if_addr = '0; b3.dp_req = 0; b3.dp_we = 0; b3.dp_addr = '0; b3.dp_wdata = '0;
  endtask

  task automatic test_reset();
    logic [39:0] o1, o3;
    reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      b1.if_req = 1'($urandom); b1.dp_req = 1'($urandom); b1.dp_we = 1'($urandom);
      b1.if_addr = 5'($urandom); b1.dp_addr = 5'($urandom); b1.dp_wdata = 8'($urandom);
      b3.if_req = 1'($urandom); b3.dp_req = 1'($urandom); b3.dp_we = 1'($urandom);
      b3.if_addr = 5'($urandom); b3.dp_addr = 5'($urandom); b3.dp_wdata = 8'($urandom);
      step();
      o1 = {b1.if_gnt, b1.if_rvalid, b1.if_rdata, b1.dp_gnt, b1.dp_rvalid, b1.dp_rdata,
            b1.mem_addr, b1.mem_din, b1.read, b1.write};
      o3 = {b3.if_gnt, b3.if_rvalid, b3.if_rdata, b3.dp_gnt, b3.dp_rvalid, b3.dp_rdata,
            b3.mem_addr, b3.mem_din, b3.read, b3.write};
      vec++;
      if (o1 !== 40'd0 || o3 !== 40'd0) begin
        err++; $display("FAIL reset_outputs cycle %0d: got %h / %h want 0", c, o1, o3);
      end
    end
    idle_inputs();
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      vec++;
      if ({b1.read, b1.write, b3.read, b3.write} !== 4'b0) begin
        err++; $display("FAIL post_reset_idle cycle %0d: strobes %b want 0000", c,
                        {b1.read, b1.write, b3.read, b3.write});
      end
    end
  endtask

  task automatic test_fetch_read();
    b1.if_req = 1; b1.if_addr = 5'h03;
    step();  // C1
    vec++;
    if ({b1.if_gnt, b1.dp_gnt, b1.read, b1.write} !== 4'b1010 || b1.mem_addr !== 5'h03) begin
      err++; $display("FAIL fetch_c1: gnt/strobe %b addr %h want 1010 addr 03",
                      {b1.if_gnt, b1.dp_gnt, b1.read, b1.write}, b1.mem_addr);
    end
    b1.if_req = 0;
    step();  // C2
    vec++;
    if ({b1.if_gnt, b1.read, b1.if_rvalid} !== 3'b000) begin
      err++; $display("FAIL fetch_c2: gnt/read/rvalid %b want 000", {b1.if_gnt, b1.read, b1.if_rvalid});
    end
    step();  // C3
    vec++;
    if (b1.if_rvalid !== 1'b1 || b1.if_rdata !== 8'hA5 || b1.dp_rvalid !== 1'b0) begin
      err++; $display("FAIL fetch_c3: rvalid %b data %h dp_rvalid %b want 1 A5 0",
                      b1.if_rvalid, b1.if_rdata, b1.dp_rvalid);
    end
    step();  // C4
    vec++;
    if (b1.if_rvalid !== 1'b0 || b1.if_rdata !== 8'hA5) begin
      err++; $display("FAIL fetch_c4: rvalid %b data %h want 0 A5 (held)", b1.if_rvalid, b1.if_rdata);
    end
  endtask

  task automatic test_dp_write();
    b1.dp_req = 1; b1.dp_we = 1; b1.dp_addr = 5'h1F; b1.dp_wdata = 8'h3C;
    step();  // C1
    vec++;
    if ({b1.if_gnt, b1.dp_gnt, b1.read, b1.write} !== 4'b0101 || b1.mem_din !== 8'h3C ||
        b1.mem_addr !== 5'h1F) begin
      err++; $display("FAIL write_c1: gnt/strobe %b din %h addr %h want 0101 3C 1F",
                      {b1.if_gnt, b1.dp_gnt, b1.read, b1.write}, b1.mem_din, b1.mem_addr);
    end
    b1.dp_req = 0; b1.dp_we = 0;
    step();  // C2: IDLE again
    vec++;
    if ({b1.write, b1.read, b1.if_rvalid, b1.dp_rvalid, b1.dp_gnt} !== 5'b0) begin
      err++; $display("FAIL write_c2: write/read/rvalids/gnt %b want 00000",
                      {b1.write, b1.read, b1.if_rvalid, b1.dp_rvalid, b1.dp_gnt});
    end
    b1.if_req = 1; b1.if_addr = 5'h1F;
    step();
    b1.if_req = 0;
    step();
    step();
    vec++;
    if (b1.if_rvalid !== 1'b1 || b1.if_rdata !== 8'h3C) begin
      err++; $display("FAIL write_readback: rvalid %b data %h want 1 3C", b1.if_rvalid, b1.if_rdata);
    end
  endtask

  task automatic test_rdlat3();
    b3.if_req = 1; b3.if_addr = 5'h02;
    step();  // C1
    vec++;
    if ({b3.if_gnt, b3.read, b3.write} !== 3'b110 || b3.mem_addr !== 5'h02) begin
      err++; $display("FAIL lat3_c1: gnt/read/write %b addr %h want 110 02",
                      {b3.if_gnt, b3.read, b3.write}, b3.mem_addr);
    end
    b3.if_req = 0;
    step(); step(); step();  // C4
    vec++;
    if (b3.if_rvalid !== 1'b0 || b3.read !== 1'b0) begin
      err++; $display("FAIL lat3_c4: rvalid %b read %b want 0 0", b3.if_rvalid, b3.read);
    end
    step();  // C5
    vec++;
    if (b3.if_rvalid !== 1'b1 || b3.if_rdata !== 8'hC3) begin
      err++; $display("FAIL lat3_c5: rvalid %b data %h want 1 C3", b3.if_rvalid, b3.if_rdata);
    end
  endtask

  task automatic test_reset_wait();
    logic seen;
    b3.dp_req = 1; b3.dp_we = 0; b3.dp_addr = 5'h07;
    step();  // C1
    vec++;
    if ({b3.dp_gnt, b3.read} !== 2'b11) begin
      err++; $display("FAIL rstwait_c1: dp_gnt/read %b want 11", {b3.dp_gnt, b3.read});
    end
    b3.dp_req = 0;
    step(); step();  // C3, in WAIT
    reset = 1'b1;
    step();
    reset = 1'b0;
    vec++;
    if ({b3.read, b3.write, b3.dp_rvalid} !== 3'b000) begin
      err++; $display("FAIL rstwait_after: read/write/rvalid %b want 000", {b3.read, b3.write, b3.dp_rvalid});
    end
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (b3.dp_rvalid === 1'b1 || b3.read === 1'b1 || b3.write === 1'b1) seen = 1'b1;
    end
    vec++;
    if (seen !== 1'b0) begin
      err++; $display("FAIL rstwait_no_rvalid: activity seen %b want 0", seen);
    end
    b3.if_req = 1; b3.if_addr = 5'h00;
    step();
    b3.if_req = 0;
    step(); step(); step(); step();  // C5
    vec++;
    if (b3.if_rvalid !== 1'b1 || b3.if_rdata !== 8'h5A || b3.dp_rvalid !== 1'b0) begin
      err++; $display("FAIL rstwait_fetch: rvalid %b data %h dp_rvalid %b want 1 5A 0",
                      b3.if_rvalid, b3.if_rdata, b3.dp_rvalid);
    end
  endtask

  task automatic test_contention();
    logic [3:0] got, want;
    int n;
    reset = 1'b1;
    step();
    reset = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
    want = 4'b1111;  // bit k = 1 means grant k went to datapath
`else
    want = 4'b1010;  // if, dp, if, dp
`endif
    got = '0;
    n = 0;
    b1.if_req = 1; b1.if_addr = 5'h04;
    b1.dp_req = 1; b1.dp_we = 1; b1.dp_addr = 5'h10; b1.dp_wdata = 8'h11;
    for (int c = 0; c < 60 && n < 4; c++) begin
      step();
      vec++;
      if ((b1.if_gnt && b1.dp_gnt) || (b1.read && b1.write)) begin
        err++; $display("FAIL contention_exclusive: gnt %b%b strobe %b%b want at most one",
                        b1.if_gnt, b1.dp_gnt, b1.read, b1.write);
      end
      if (b1.if_gnt || b1.dp_gnt) begin
        got[n] = b1.dp_gnt;
        n++;
      end
    end
    vec++;
    if (n != 4 || got !== want) begin
      err++; $display("FAIL contention_order: %0d grants pattern %b want 4 grants %b", n, got, want);
    end
    b1.dp_req = 0; b1.dp_we = 0;
`ifdef ARB_FIXED_PRIO_EN
    n = 0;
    for (int c = 0; c < 10 && n == 0; c++) begin
      step();
      if (b1.if_gnt || b1.dp_gnt) n = b1.if_gnt ? 1 : 2;
    end
    vec++;
    if (n != 1) begin
      err++; $display("FAIL contention_fetch_after_dp: grant code %0d want 1 (fetch)", n);
    end
`endif
    b1.if_req = 0;
    for (int c = 0; c < 6; c++) step();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_fetch_read();
    test_dp_write();
    test_rdlat3();
    test_reset_wait();
    test_contention();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule

// File: doc/cisc_mem_arbiter.md
# cisc_mem_arbiter

Shares the single 32 x 8 CPU memory between two requesters of the CISC core: the instruction-fetch unit (read-only) and the execute datapath (read/write). Arbitrates requests, sequences each access as a one-cycle read or write strobe on the memory bus, waits out the memory read latency and returns read data with a one-cycle valid pulse. Sits between the core's control unit and the memory, driving `mem_addr`, `read` and `write`, and sampling `mem_out`.

## Interface
- `ADDR_W`, 5: memory address width.
- `DATA_W`, 8: memory data width.
- `RD_LAT`, 1: memory read latency in cycles from the read strobe to valid `mem_out`; legal range 1..7.

- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `if_req`  in  1  fetch request; held until `if_gnt` is seen.
- `if_addr`  in  ADDR_W  fetch address.
- `if_gnt`  out  1  one-cycle grant to fetch.
- `if_rvalid`  out  1  one-cycle fetch read-data valid.
- `if_rdata`  out  DATA_W  fetch read data.
- `dp_req`  in  1  datapath request; held until `dp_gnt` is seen.
- `dp_we`  in  1  1 = write, 0 = read.
- `dp_addr`  in  ADDR_W  datapath address.
- `dp_wdata`  in  DATA_W  datapath write data.
- `dp_gnt`  out  1  one-cycle grant to datapath.
- `dp_rvalid`  out  1  one-cycle datapath read-data valid.
- `dp_rdata`  out  DATA_W  datapath read data.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_din`  out  DATA_W  memory write data.
- `read`  out  1  memory read strobe.
- `write`  out  1  memory write strobe.
- `mem_out`  in  DATA_W  memory read data.

## Operation
- FSM states: IDLE, ACCESS, WAIT.
- IDLE: if any request, pick a winner, register its address, write enable and write data, and go to ACCESS. With no request, stay in IDLE.
- ACCESS (exactly 1 cycle): the winner's `*_gnt` is 1. Also drives `mem_addr` and either `read` = 1 or `write` = 1 (fetch is always a read).
  - Write: return to IDLE.
  - Read: go to WAIT with the latency counter loaded to RD_LAT.
- WAIT: the counter decrements each cycle. On the last WAIT cycle, `mem_out` is captured into the owner's `*_rdata`. The `*_rvalid` pulse follows in the next cycle, concurrent with IDLE.
- Arbitration is round-robin. On simultaneous requests, the port not granted most recently wins. After reset, fetch wins the first tie.
- Requests are ignored outside IDLE. A requester drops `req` the cycle after its grant, so a `req` still high in IDLE is a new request.
- `mem_addr`, `mem_din` and the `*_rdata` registers hold their values until overwritten. `read`, `write`, `*_gnt` and `*_rvalid` are pulses.
- Reset values: every output is 0, state is IDLE and the last-grant pointer is datapath.
- Reset mid-access: the access is aborted, no `rvalid` is issued and no strobe is emitted in the cycle after reset.

## Timing
- Request sampled in IDLE at cycle C0 gives grant plus strobe in C1.
- Write: 2 cycles per access (C1 ACCESS, back to IDLE in C2).
- Read: `rvalid` in cycle C(2+RD_LAT), which is also an IDLE cycle able to arbitrate.
- Back-to-back reads: one access every RD_LAT+2 cycles.
- `read` and `write` are never 1 together. At most one `gnt` and at most one `rvalid` is high per cycle.

## Configuration
- `ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority, datapath always wins ties, and the last-grant pointer is not implemented.
  - Undefined: round-robin as described above.

## Test plan
- Reset: hold `reset` for 5 cycles with random requests → all outputs 0. After release with no request, `read` = `write` = 0 indefinitely.
- Fetch read: `if_addr` = 5'h03, memory holds 8'hA5 at address 3, RD_LAT = 1 → `if_gnt` and `read` high only in C1 with `mem_addr` = 3; `if_rvalid` = 1 with `if_rdata` = 8'hA5 in C3.
- Datapath write: `dp_we` = 1, addr 5'h1F, data 8'h3C → `write` = 1 only in C1 with `mem_din` = 8'h3C and no `rvalid`. A following fetch of 5'h1F returns 8'h3C.
- Contention: both ports re-request immediately after every grant → grants go if, dp, if, dp. With `ARB_FIXED_PRIO_EN`, grants go dp, dp, …, and fetch is granted only once `dp_req` stays low.
- Reset during WAIT of a datapath read (RD_LAT = 3) → no `dp_rvalid` ever appears. After release, a fetch of 5'h00 completes normally.
- RD_LAT = 3 fetch read → `if_rvalid` in C5, with data captured from `mem_out` in C4.
